// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
//   Shared definitions for the systolic-array operand feeder:
//     - state_e         : feeder FSM state encoding (IDLE/FEED/DONE)
//     - DEF_DATA_WIDTH  : default signed operand width
//     - DEF_DIM         : default array dimension
//     - FEED_CYCLES()   : number of FEED cycles for a DIM x DIM multiply
// -----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DIM        = 4;

    // Skewed streaming of DIM operands per edge takes 3*DIM-2 cycles.
    function automatic int unsigned FEED_CYCLES(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/matmul_operand_mem.sv
// -----------------------------------------------------------------------------
// matmul_operand_mem
//   DIM x DIM operand register file: one synchronous write port, all elements
//   readable combinationally, asynchronous active-low reset to zero.
//   Ports:
//     clk_i, rst_ni          clock, async active-low reset
//     wr_en_i                write strobe (already qualified by the caller)
//     wr_row_i, wr_col_i     element index (caller guarantees < DIM)
//     wr_data_i              element value
//     rd_data_o              flattened contents, element (r,c) at
//                            [(r*DIM+c)*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module matmul_operand_mem
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DIM        = DEF_DIM,
    parameter int unsigned IDX_W      = $clog2(DIM)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            wr_en_i,
    input  logic [IDX_W-1:0]                wr_row_i,
    input  logic [IDX_W-1:0]                wr_col_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    output logic [DIM*DIM*DATA_WIDTH-1:0]   rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DIM][DIM];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < DIM; r++) begin
                for (int unsigned c = 0; c < DIM; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wr_en_i) begin
            mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        for (genvar c = 0; c < DIM; c++) begin : g_col
            assign rd_data_o[(r*DIM+c)*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][c];
        end
    end

endmodule

// File: rtl/matmul_operand_feeder.sv
// -----------------------------------------------------------------------------
// matmul_operand_feeder
//   Holds matrices A and B and streams them, diagonally skewed, into the edges
//   of a DIM x DIM systolic multiply array. Row i of A drives the left edge of
//   array row i, column j of B drives the top edge of array column j. After the
//   stream the array is held in accumulate-hold (pe_start_o=1, operands 0)
//   until clear_i.
//   Ports:
//     clk_i, rst_ni          clock, async active-low reset
//     start_i                begin a multiply (IDLE only, no write that cycle)
//     clear_i                abort FEED / release DONE, back to IDLE
//     wr_en_i, wr_sel_i      element write strobe, 0 = A, 1 = B
//     wr_row_i, wr_col_i     element index
//     wr_data_i              signed element value
//     wr_ready_o             writes accepted (IDLE and DONE)
//     a_row_o, b_col_o       skewed operand slices for the array edges
//     pe_start_o             start/hold line for every PE
//     busy_o, done_o         FEED / DONE indication
//     wr_err_o               sticky bad-write flag (FEEDER_WR_ERR_EN only)
//   Build option:
//     FEEDER_WR_ERR_EN       adds wr_err_o; otherwise bad writes drop silently
// -----------------------------------------------------------------------------
module matmul_operand_feeder
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DIM        = DEF_DIM,
    parameter int unsigned IDX_W      = $clog2(DIM)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        clear_i,
    input  logic                        wr_en_i,
    input  logic                        wr_sel_i,
    input  logic [IDX_W-1:0]            wr_row_i,
    input  logic [IDX_W-1:0]            wr_col_i,
    input  logic [DATA_WIDTH-1:0]       wr_data_i,
    output logic                        wr_ready_o,
    output logic [DIM*DATA_WIDTH-1:0]   a_row_o,
    output logic [DIM*DATA_WIDTH-1:0]   b_col_o,
    output logic                        pe_start_o,
    output logic                        busy_o,
    output logic                        done_o
`ifdef FEEDER_WR_ERR_EN
    ,
    output logic                        wr_err_o
`endif
);

    localparam int unsigned CNT_W  = $clog2(FEED_CYCLES(DIM));
    localparam int unsigned LAST_T = FEED_CYCLES(DIM) - 1;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           t_q, t_d;
    logic [DIM*DATA_WIDTH-1:0]  a_row_q, a_row_d;
    logic [DIM*DATA_WIDTH-1:0]  b_col_q, b_col_d;
    logic                       pe_start_q, pe_start_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       wr_ready_q, wr_ready_d;

    logic                           idx_ok;
    logic                           wr_accept;
    logic [DIM*DIM*DATA_WIDTH-1:0]  a_flat, b_flat;

    // A power-of-two DIM leaves no out-of-range index encodings.
    if (DIM == (1 << IDX_W)) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_check
        assign idx_ok = (32'(wr_row_i) < DIM) && (32'(wr_col_i) < DIM);
    end

    assign wr_accept = wr_en_i && wr_ready_q && idx_ok;

    matmul_operand_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM),
        .IDX_W      (IDX_W)
    ) u_mem_a (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_en_i    (wr_accept && !wr_sel_i),
        .wr_row_i   (wr_row_i),
        .wr_col_i   (wr_col_i),
        .wr_data_i  (wr_data_i),
        .rd_data_o  (a_flat)
    );

    matmul_operand_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM),
        .IDX_W      (IDX_W)
    ) u_mem_b (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_en_i    (wr_accept && wr_sel_i),
        .wr_row_i   (wr_row_i),
        .wr_col_i   (wr_col_i),
        .wr_data_i  (wr_data_i),
        .rd_data_o  (b_flat)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!clear_i && start_i && !wr_en_i) begin
                    state_d = ST_FEED;
                    t_d     = '0;
                end
            end
            ST_FEED: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else if (t_q == CNT_W'(LAST_T)) begin
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next state/count.
    // Row slice i carries A[i][k] and column slice i carries B[k][i] exactly
    // when t == i + k, so one loop nest produces both skews.
    always_comb begin
        pe_start_d = (state_d != ST_IDLE);
        busy_d     = (state_d == ST_FEED);
        done_d     = (state_d == ST_DONE);
        wr_ready_d = (state_d != ST_FEED);
        a_row_d    = '0;
        b_col_d    = '0;
        if (state_d == ST_FEED) begin
            for (int unsigned i = 0; i < DIM; i++) begin
                for (int unsigned k = 0; k < DIM; k++) begin
                    if (t_d == CNT_W'(i + k)) begin
                        a_row_d[i*DATA_WIDTH +: DATA_WIDTH] =
                            a_flat[(i*DIM+k)*DATA_WIDTH +: DATA_WIDTH];
                        b_col_d[i*DATA_WIDTH +: DATA_WIDTH] =
                            b_flat[(k*DIM+i)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            a_row_q    <= '0;
            b_col_q    <= '0;
            pe_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            a_row_q    <= a_row_d;
            b_col_q    <= b_col_d;
            pe_start_q <= pe_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    assign a_row_o    = a_row_q;
    assign b_col_o    = b_col_q;
    assign pe_start_o = pe_start_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign wr_ready_o = wr_ready_q;

`ifdef FEEDER_WR_ERR_EN
    logic wr_err_q, wr_err_d;

    always_comb begin
        wr_err_d = wr_err_q;
        if (clear_i) begin
            wr_err_d = 1'b0;
        end else if (wr_en_i && (!wr_ready_q || !idx_ok)) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err_o = wr_err_q;
`endif

endmodule

// File: doc/matmul_operand_feeder.md
# matmul_operand_feeder

Upstream feeder for the DIM×DIM systolic multiply array. It holds matrices A and B in local register files, loaded through a write port. On command it streams them into the array edges with diagonal skew and drives the array's start line: row i of A enters the left edge, column j of B enters the top edge. It then holds the array in accumulate-hold until software clears it.

## Interface
- DATA_WIDTH, 8, signed operand width; must match the PE array.
- DIM, 4, array dimension (≥2); matrices are DIM×DIM.
- IDX_W, $clog2(DIM), row/column index width (derived).
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  begin one multiplication; sampled in IDLE only.
- clear_i  in  1  abort FEED, or release DONE; returns to IDLE.
- wr_en_i  in  1  write one matrix element.
- wr_sel_i  in  1  0 = matrix A, 1 = matrix B.
- wr_row_i, wr_col_i  in  IDX_W each  element index.
- wr_data_i  in  DATA_WIDTH  signed element value.
- wr_ready_o  out  1  writes accepted.
- a_row_o  out  DIM*DATA_WIDTH  slice i → left edge of array row i.
- b_col_o  out  DIM*DATA_WIDTH  slice j → top edge of array column j.
- pe_start_o  out  1  drives every PE start input.
- busy_o  out  1  high in FEED.
- done_o  out  1  high in DONE; array results final.
- wr_err_o  out  1  present only with FEEDER_WR_ERR_EN.

## Operation
- States: IDLE, FEED, DONE. Cycle counter t runs 0..3*DIM-3 in FEED.
- IDLE
  - All data outputs are 0; pe_start_o=0.
  - clear_i has priority over start_i.
  - With start_i=1, wr_en_i=0 and clear_i=0 → FEED, t=0.
  - With start_i and wr_en_i both high, the write is performed and start is ignored.
- FEED
  - Row slice i = A[i][t-i] when 0 ≤ t-i < DIM, else 0.
  - Column slice j = B[t-j][j] when 0 ≤ t-j < DIM, else 0.
  - pe_start_o=1; busy_o=1; wr_ready_o=0.
  - Writes are dropped.
  - At t=3*DIM-3 → DONE.
  - clear_i → IDLE immediately, which drops pe_start_o and clears the array.
- DONE
  - pe_start_o stays 1 with all operands 0, so the array holds its results.
  - done_o=1.
  - clear_i → IDLE.
  - start_i is ignored.
  - Writes are accepted, allowing the next operands to be preloaded.
- Writes
  - Accepted when wr_en_i && wr_ready_o; wr_ready_o=1 in IDLE and DONE.
  - Out-of-range index (≥DIM) is dropped.
- Arithmetic: operands are passed through unmodified as two's-complement; there is no sign extension.

## Timing
- All outputs are registered.
- Reset value of every output is 0. Reset also zeroes both register files and forces IDLE.
- Reset mid-FEED aborts the run; no partial state survives.
- Start latency: start_i sampled at edge E0. After E0, pe_start_o=1 and operands are for t=0. The array accumulates the t=0 operands at E1.
- Write latency: the element is visible to FEED from the cycle after the write edge.
- Skew: PE(i,j) accumulates A[i][k]·B[k][j] at the edge ending feeder cycle i+j+k.
- The last accumulate (DIM-1,DIM-1,DIM-1) occurs at the edge ending t=3*DIM-3. That same edge sets done_o, so done_o rises in the same cycle the final res_o values appear.
- FEED length is exactly 3*DIM-2 cycles; busy_o is high for exactly that many cycles.
- The cycle after clear_i is sampled has pe_start_o=0. The array clears at the following edge.

## Configuration
- FEEDER_WR_ERR_EN defined
  - wr_err_o exists.
  - Set to 1 on any wr_en_i while wr_ready_o=0, or on any out-of-range index.
  - Sticky; cleared only by reset or by clear_i.
- FEEDER_WR_ERR_EN undefined
  - Port is absent.
  - Such writes are silently dropped.

## Structure
- Package matmul_pkg holds:
  - the state typedef (IDLE/FEED/DONE encoding);
  - the default DATA_WIDTH and DIM;
  - the FEED_CYCLES = 3*DIM-2 function.
- Sub-module matmul_operand_mem: a DIM×DIM register file with one synchronous write port, combinational read of all elements, and reset-to-zero. It is instantiated twice, for A and B.
- The skew mux and FSM live in the top-level module.

## Test plan
- DIM=2, A=[[1,2],[3,4]], B=identity; load, then start → done_o after 4 FEED cycles. Attached array res = [[1,2],[3,4]].
- DIM=2, A=[[-1,2],[3,-4]], B=[[5,6],[7,8]] → a_row_o slice 1 is 0, 3, -4, 0 across t=0..3. Array res = [[9,10],[-13,-14]].
- Assert clear_i at t=1 of FEED → IDLE next cycle with pe_start_o=0 and busy_o=0. A following start → correct full result.
- Write during FEED → dropped, memory contents unchanged. With FEEDER_WR_ERR_EN, wr_err_o=1 until clear_i.
- Assert start_i and wr_en_i in the same IDLE cycle → write stored, state remains IDLE. Preload in DONE then clear+start → the new matrices are used.
- Assert rst_ni low mid-FEED → all outputs 0 on the same cycle, and memories read back as 0.
